// File: rtl/tty_serial_tx.sv
// Teletype serial transmitter: frames a parallel character as start, data (LSB first) and stop bits,
// paced by rising edges of the sampled 2x-baud square wave.
module tty_serial_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_x2,
    input  logic       load,
    input  logic [7:0] tx_data,
    input  logic       flag_clr,
    output logic       ser_out,
    output logic       busy,
    output logic       tx_flag,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [1:0] CELL_LAST = 2'd1;
    localparam logic [1:0] STOP_LAST = 2'(2 * STOP_BITS - 1);
    localparam logic [3:0] BITS_LAST = 4'(DATA_BITS - 1);

    state_t               state;
    logic                 baud_prev;
    logic                 tick;
    logic [DATA_BITS-1:0] shift_reg;
    logic [3:0]           bit_cnt;
    logic [1:0]           tick_cnt;

    // baud_prev resets high so a baud_x2 that is already high after reset is not a tick
    assign tick = baud_x2 & ~baud_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_prev <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tick_cnt  <= '0;
            ser_out   <= 1'b1;
            busy      <= 1'b0;
            tx_flag   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            baud_prev <= baud_x2;

            // Clearing comes first so that setting the flag on the last stop tick wins
            if (flag_clr) begin
                tx_flag <= 1'b0;
                overrun <= 1'b0;
            end
            if (load && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= tx_data[DATA_BITS-1:0];
                        busy      <= 1'b1;
                        tx_flag   <= 1'b0;
                        state     <= SYNC;
                    end
                end
                SYNC: begin
                    if (tick) begin
                        ser_out  <= 1'b0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == CELL_LAST) begin
                            ser_out  <= shift_reg[0];
                            bit_cnt  <= '0;
                            tick_cnt <= '0;
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 2'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == CELL_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == BITS_LAST) begin
                                ser_out <= 1'b1;
                                state   <= STOP;
                            end else begin
                                ser_out   <= shift_reg[1];
                                shift_reg <= shift_reg >> 1;
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 2'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            busy     <= 1'b0;
                            tx_flag  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tty_serial_tx.sv
// Bench for tty_serial_tx: an 8N2 and a 7N1 instance driven with directed and random characters,
// line bits compared against a frame built from the character and framing rules.
module tb_tty_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_x2 = 1'b0;
    logic       baud_run = 1'b1;
    logic       load8 = 1'b0;
    logic       load7 = 1'b0;
    logic       flag_clr = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic ser8, busy8, flag8, ovr8;
    logic ser7, busy7, flag7, ovr7;

    int checks = 0;
    int errors = 0;

    tty_serial_tx dut8 (
        .clk(clk), .rst_n(rst_n), .baud_x2(baud_x2), .load(load8), .tx_data(tx_data),
        .flag_clr(flag_clr), .ser_out(ser8), .busy(busy8), .tx_flag(flag8), .overrun(ovr8)
    );

    tty_serial_tx #(.DATA_BITS(7), .STOP_BITS(1)) dut7 (
        .clk(clk), .rst_n(rst_n), .baud_x2(baud_x2), .load(load7), .tx_data(tx_data),
        .flag_clr(flag_clr), .ser_out(ser7), .busy(busy7), .tx_flag(flag7), .overrun(ovr7)
    );

    always #5 clk = ~clk;

    // baud_x2 toggles every 4 clocks, giving a tick every 8 clocks and a 16-clock bit cell
    initial forever begin
        repeat (4) @(negedge clk);
        if (baud_run) baud_x2 = ~baud_x2;
    end

    function automatic logic ser_of(input bit u7);
        return u7 ? ser7 : ser8;
    endfunction
    function automatic logic busy_of(input bit u7);
        return u7 ? busy7 : busy8;
    endfunction
    function automatic logic flag_of(input bit u7);
        return u7 ? flag7 : flag8;
    endfunction
    function automatic logic ovr_of(input bit u7);
        return u7 ? ovr7 : ovr8;
    endfunction

    task automatic set_load(input bit u7, input logic v);
        if (u7) load7 = v;
        else load8 = v;
    endtask

    task automatic wait_start(input string name, input bit u7, output bit ok);
        int t = 0;
        while (ser_of(u7) !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        ok = (ser_of(u7) === 1'b0);
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s start bit: ser_out=%b after %0d clks, expected 0", name, ser_of(u7), t);
        end
    endtask

    task automatic check_frame(input string name, input bit u7, input logic [7:0] d, input bit do_load,
                               input bit clr_on_load, input int inject_k, input int clr_k);
        int   nd = u7 ? 7 : 8;
        int   ns = u7 ? 1 : 2;
        int   ncell = 1 + nd + ns;
        logic exp_bits[$];
        bit   ok;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) exp_bits.push_back(d[i]);
        for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);

        if (do_load) begin
            tx_data = d;
            set_load(u7, 1'b1);
            if (clr_on_load) flag_clr = 1'b1;
            @(negedge clk);
            set_load(u7, 1'b0);
            flag_clr = 1'b0;
            checks++;
            if (busy_of(u7) !== 1'b1 || flag_of(u7) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s accept: busy=%b tx_flag=%b, expected busy=1 tx_flag=0",
                         name, busy_of(u7), flag_of(u7));
            end
            if (clr_on_load) begin
                checks++;
                if (ovr_of(u7) !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s load+clr: overrun=%b, expected 0", name, ovr_of(u7));
                end
            end
        end

        wait_start(name, u7, ok);
        if (!ok) return;

        for (int k = 0; k <= 16 * ncell; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 16 == 8) begin
                checks++;
                if (ser_of(u7) !== exp_bits[k/16] || busy_of(u7) !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s cell %0d: ser_out=%b busy=%b, expected ser_out=%b busy=1",
                             name, k / 16, ser_of(u7), busy_of(u7), exp_bits[k/16]);
                end
            end
            if (k == 16 * ncell - 1) begin
                checks++;
                if (flag_of(u7) !== 1'b0 || busy_of(u7) !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s pre-done: tx_flag=%b busy=%b, expected tx_flag=0 busy=1",
                             name, flag_of(u7), busy_of(u7));
                end
            end
            if (k == 16 * ncell) begin
                checks++;
                if (flag_of(u7) !== 1'b1 || busy_of(u7) !== 1'b0 || ser_of(u7) !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s done: tx_flag=%b busy=%b ser_out=%b, expected 1 0 1",
                             name, flag_of(u7), busy_of(u7), ser_of(u7));
                end
            end
            set_load(u7, k == inject_k);
            flag_clr = (k == clr_k);
        end
        set_load(u7, 1'b0);
        flag_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ser8 !== 1'b1 || busy8 !== 1'b0 || flag8 !== 1'b0 || ovr8 !== 1'b0 ||
            ser7 !== 1'b1 || busy7 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: ser=%b busy=%b flag=%b ovr=%b ser7=%b busy7=%b, expected 1 0 0 0 1 0",
                     ser8, busy8, flag8, ovr8, ser7, busy7);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat (10) @(negedge clk);
            checks++;
            if (ser8 !== 1'b1 || busy8 !== 1'b0 || flag8 !== 1'b0 || ser7 !== 1'b1 || busy7 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle %0d: ser=%b busy=%b flag=%b ser7=%b busy7=%b, expected 1 0 0 1 0",
                         i, ser8, busy8, flag8, ser7, busy7);
            end
        end
    endtask

    task automatic test_default_frame();
        check_frame("frame_41", 1'b0, 8'h41, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_short_frame();
        check_frame("frame7_ff", 1'b1, 8'hFF, 1'b1, 1'b0, -1, -1);
        checks++;
        if (ovr7 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame7 overrun: overrun=%b, expected 0", ovr7);
        end
    endtask

    task automatic test_overrun();
        check_frame("overrun_55", 1'b0, 8'h55, 1'b1, 1'b0, 16 * 4 + 8, -1);
        checks++;
        if (ovr8 !== 1'b1 || flag8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun set: overrun=%b tx_flag=%b, expected 1 1", ovr8, flag8);
        end
        pulse_clr();
        checks++;
        if (ovr8 !== 1'b0 || flag8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun clr: overrun=%b tx_flag=%b, expected 0 0", ovr8, flag8);
        end
    endtask

    task automatic test_flag_race();
        check_frame("clr_race", 1'b0, 8'($urandom), 1'b1, 1'b0, -1, 16 * 11 - 1);
        repeat (3) @(negedge clk);
        pulse_clr();
        checks++;
        if (flag8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL second clr: tx_flag=%b, expected 0", flag8);
        end
    endtask

    task automatic test_load_at_finish();
        check_frame("late_load", 1'b0, 8'($urandom), 1'b1, 1'b0, 16 * 11 - 1, -1);
        checks++;
        if (ovr8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late load: overrun=%b busy=%b, expected 1 0", ovr8, busy8);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || ser8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late load ignored: busy=%b ser_out=%b, expected 0 1", busy8, ser8);
        end
        check_frame("load_with_clr", 1'b0, 8'($urandom), 1'b1, 1'b1, -1, -1);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        tx_data = 8'h0F;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        wait_start("rst_mid", 1'b0, ok);
        repeat (16 * 3 + 4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ser8 !== 1'b1 || busy8 !== 1'b0 || flag8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async reset: ser_out=%b busy=%b tx_flag=%b, expected 1 0 0", ser8, busy8, flag8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_frame("after_rst_0f", 1'b0, 8'h0F, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_stuck_baud(input logic lvl);
        logic [7:0] d = 8'($urandom);
        int t = 0;
        while (baud_x2 !== lvl && t < 20) begin
            @(negedge clk);
            t++;
        end
        baud_run = 1'b0;
        tx_data = d;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || ser8 !== 1'b1 || baud_x2 !== lvl) begin
            errors++;
            $display("[TB] FAIL stuck baud %b: busy=%b ser_out=%b, expected 1 1", lvl, busy8, ser8);
        end
        baud_run = 1'b1;
        check_frame("after_stuck", 1'b0, d, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d = 8'($urandom);
            int gap = (i < 2) ? 0 : int'($urandom_range(0, 20));
            bit u7 = i[0];
            repeat (gap) @(negedge clk);
            check_frame(u7 ? "rand7" : "rand8", u7, d, 1'b1, 1'($urandom_range(0, 1)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_short_frame();
        test_overrun();
        test_flag_race();
        test_load_at_finish();
        test_reset_midframe();
        test_stuck_baud(1'b1);
        test_stuck_baud(1'b0);
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tty_serial_tx.md
Name: tty_serial_tx

Overview:
- Teletype serial transmitter stage. Sits directly downstream of the variable baud clock divider and consumes its 2x-baud square-wave output.
- Takes a parallel character from the CPU-side IOT logic. Shifts it out as an asynchronous frame: start bit, data bits LSB first, stop bits.
- Raises a done flag for the IOT skip/interrupt logic once the frame is finished.
- Everything runs on the 100 MHz system clock. The baud input is sampled, not used as a clock.

Parameters:
- DATA_BITS, 8, number of data bits per frame, legal 5..8.
- STOP_BITS, 2, number of stop bits, legal 1..2. The default of 2 matches ASR-33 110 baud framing.

Ports:
- clk, input, 1, 100 MHz system clock.
- rst_n, input, 1, asynchronous active-low reset.
- baud_x2, input, 1, 2x-baud square wave from the variable clock divider. Level signal, synchronous to clk.
- load, input, 1, one-cycle strobe: latch tx_data and start a frame.
- tx_data, input, 8, character to send. Bits above DATA_BITS-1 are ignored.
- flag_clr, input, 1, one-cycle strobe: clear tx_flag.
- ser_out, output, 1, serial line. 1 = mark/idle, 0 = space.
- busy, output, 1, high from an accepted load until the frame completes.
- tx_flag, output, 1, done flag. Sticky until cleared.
- overrun, output, 1, sticky. Set by a load while busy. Cleared by flag_clr or reset.

Behaviour:
- Reset (async assert, sync release):
  - ser_out=1, busy=0, tx_flag=0, overrun=0.
  - State IDLE, shift register and counters cleared.
  - Reset mid-frame abandons the frame immediately; the line returns to mark.
- tick:
  - Defined as baud_x2==1 this cycle and baud_x2==0 the previous cycle.
  - The previous-value register resets to 1, so no spurious tick occurs after reset.
  - Each bit cell lasts exactly 2 ticks.
- States: IDLE -> SYNC -> START -> DATA -> STOP -> IDLE.
- IDLE, load=1:
  - Latch tx_data[DATA_BITS-1:0] into the shift register.
  - busy=1 and tx_flag=0 next cycle.
  - Go to SYNC.
- SYNC:
  - Wait for the first tick. On that tick, ser_out=0 (registered, visible the next cycle) and go to START.
  - This aligns bit edges to the baud clock, so load-to-start-bit latency is 1 to (one baud_x2 period + 1) cycles.
- START:
  - After 2 ticks, drive ser_out=shift[0], set bit counter=0, go to DATA.
- DATA:
  - Every 2nd tick: shift right and increment the bit counter.
  - If the counter reaches DATA_BITS: ser_out=1 and go to STOP.
  - Otherwise drive the next bit.
- STOP:
  - Hold ser_out=1 for 2*STOP_BITS ticks.
  - On the final tick: busy=0, tx_flag=1, go to IDLE.
  - The line stays at mark.
- load while busy (SYNC..STOP):
  - Ignored: data is not latched and the frame is undisturbed.
  - overrun=1.
- load in the same cycle busy falls: the state is still STOP, so the load is ignored and overrun=1.
- flag_clr=1:
  - tx_flag=0 and overrun=0 next cycle.
  - If flag_clr coincides with the flag being set on the final STOP tick, set wins: tx_flag=1.
- load and flag_clr in the same IDLE cycle: the load is accepted, the flag is cleared, overrun is cleared.
- baud_x2 stuck at either level: no ticks, so the FSM holds its state indefinitely. No timeout.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset with baud_x2 toggling every 4 clks (tick every 8 clks). Hold rst_n=0 then release -> ser_out=1, busy=0, tx_flag=0. No activity for 200 clks.
- Defaults, load tx_data=8'h41 -> after the first tick, ser_out bit sequence at 16-clk cells is 0,1,0,0,0,0,0,1,0,1,1. busy stays high throughout. tx_flag rises on the tick ending the 2nd stop cell. busy falls that same cycle.
- DATA_BITS=7, STOP_BITS=1, load 8'hFF -> frame 0,1,1,1,1,1,1,1,1 (7 data bits plus 1 stop). Total 9 cells = 18 ticks from the first tick to tx_flag.
- Mid-frame load of 8'h00 during bit 3 of an 8'h55 frame -> 8'h55 frame unchanged, overrun=1. flag_clr afterwards -> overrun=0, tx_flag=0.
- flag_clr asserted in the exact cycle of the final STOP tick -> tx_flag=1 next cycle. A second flag_clr later clears it.
- rst_n pulsed low during DATA of an 8'h0F frame -> ser_out=1, busy=0 asynchronously. A subsequent load 8'h0F produces a complete, correct frame.
